// File: rtl/mux_vector_sequencer.sv
// rtl/mux_vector_sequencer.sv - clocked exhaustive sweep/checker for a 3-input select stage (z = c ? b : a)
module mux_vector_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int REPEAT        = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             z,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             err_valid,
  output logic [2:0]       err_vec,
  output logic [2:0]       first_fail_vec,
  output logic             any_fail
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       LAST_SWEEP  = 8'(REPEAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t     state_q, state_d;
  logic [2:0] vec;
  logic [3:0] settle_cnt;
  logic [7:0] sweep_cnt;
  logic       expected;
  logic       match;
  logic       last_vec;

  assign a = vec[2];
  assign b = vec[1];
  assign c = vec[0];

  assign expected = vec[0] ? vec[1] : vec[2];
  // Case equality so an X or Z on z is scored as a mismatch rather than ignored.
  assign match    = (z === expected);
  assign last_vec = (vec == 3'd7) && (sweep_cnt == LAST_SWEEP);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == 4'd0) state_d = CHECK;
      end
      CHECK: begin
        busy    = 1'b1;
        state_d = last_vec ? DONE : SETTLE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = SETTLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vec            <= 3'd0;
      settle_cnt     <= 4'd0;
      sweep_cnt      <= 8'd0;
      pass_count     <= '0;
      fail_count     <= '0;
      err_valid      <= 1'b0;
      err_vec        <= 3'd0;
      first_fail_vec <= 3'd0;
      any_fail       <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            vec            <= 3'd0;
            sweep_cnt      <= 8'd0;
            settle_cnt     <= SETTLE_LOAD;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_vec <= 3'd0;
            any_fail       <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        CHECK: begin
          if (match) begin
            if (pass_count != CNT_MAX) pass_count <= pass_count + 1'b1;
          end else begin
            if (fail_count != CNT_MAX) fail_count <= fail_count + 1'b1;
            err_valid <= 1'b1;
            err_vec   <= vec;
            if (!any_fail) begin
              first_fail_vec <= vec;
              any_fail       <= 1'b1;
            end
          end
          settle_cnt <= SETTLE_LOAD;
          // On the final vector vec stays at 7 so a/b/c hold 1,1,1 in DONE.
          if (!last_vec) begin
            vec <= vec + 3'd1;
            if (vec == 3'd7) sweep_cnt <= sweep_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_vector_sequencer.sv
// tb/tb_mux_vector_sequencer.sv - randomized bench running three parameterisations side by side
module tb_mux_vector_sequencer;

  localparam int NI = 3;
  localparam int SC [NI] = '{1, 3, 1};
  localparam int RP [NI] = '{1, 1, 40};

  logic clk = 1'b0;
  logic reset;
  logic start;

  logic [7:0] flip [NI];
  logic       xen  [NI];
  logic [2:0] xv   [NI];

  logic [2:0] abc_w  [NI];
  logic       busy_w [NI];
  logic       done_w [NI];
  logic [7:0] pc_w   [NI];
  logic [7:0] fc_w   [NI];
  logic       ev_w   [NI];
  logic [2:0] evec_w [NI];
  logic [2:0] ffv_w  [NI];
  logic       af_w   [NI];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic gold(input logic [2:0] v);
    return v[0] ? v[1] : v[2];
  endfunction

  // Fault-injected stage: golden value, optionally inverted per vector, or X on one vector.
  function automatic logic zfun(input logic [7:0] fm, input logic xe, input logic [2:0] xvv,
                                input logic [2:0] v);
    logic r;
    r = gold(v) ^ fm[v];
    if (xe && (v == xvv)) r = 1'bx;
    return r;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic a, b, c, busy, done, ev, af, z;
    logic [7:0] pc, fc;
    logic [2:0] evec, ffv;

    assign z = zfun(flip[g], xen[g], xv[g], {a, b, c});

    mux_vector_sequencer #(
      .SETTLE_CYCLES(SC[g]),
      .REPEAT       (RP[g]),
      .CNT_W        (8)
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .z             (z),
      .a             (a),
      .b             (b),
      .c             (c),
      .busy          (busy),
      .done          (done),
      .pass_count    (pc),
      .fail_count    (fc),
      .err_valid     (ev),
      .err_vec       (evec),
      .first_fail_vec(ffv),
      .any_fail      (af)
    );

    assign abc_w[g]  = {a, b, c};
    assign busy_w[g] = busy;
    assign done_w[g] = done;
    assign pc_w[g]   = pc;
    assign fc_w[g]   = fc;
    assign ev_w[g]   = ev;
    assign evec_w[g] = evec;
    assign ffv_w[g]  = ffv;
    assign af_w[g]   = af;
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      expect_eq($sformatf("%s_busy%0d", tag, i), busy_w[i], 0);
      expect_eq($sformatf("%s_done%0d", tag, i), done_w[i], 0);
      expect_eq($sformatf("%s_abc%0d", tag, i), abc_w[i], 0);
      expect_eq($sformatf("%s_pc%0d", tag, i), pc_w[i], 0);
      expect_eq($sformatf("%s_fc%0d", tag, i), fc_w[i], 0);
      expect_eq($sformatf("%s_ev%0d", tag, i), ev_w[i], 0);
      expect_eq($sformatf("%s_evec%0d", tag, i), evec_w[i], 0);
      expect_eq($sformatf("%s_ffv%0d", tag, i), ffv_w[i], 0);
      expect_eq($sformatf("%s_af%0d", tag, i), af_w[i], 0);
    end
  endtask

  function automatic bit vec_fails(input int i, input logic [2:0] v);
    return zfun(flip[i], xen[i], xv[i], v) !== gold(v);
  endfunction

  // One run: start is driven in cycle 0 and sampled on the next edge (t=0 is the first busy cycle).
  // Vector k occupies t in [k*(S+1), k*(S+1)+S]; DONE appears at t = 8*R*(S+1).
  task automatic do_run(input string tag, input int hold);
    int len [NI];
    int maxlen;
    int npass, nfail, ffirst, per, k;
    maxlen = 0;
    for (int i = 0; i < NI; i++) begin
      len[i] = 8 * RP[i] * (SC[i] + 1);
      if (len[i] > maxlen) maxlen = len[i];
    end
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t <= maxlen + 2; t++) begin
      if (t >= hold) start = 1'b0;
      for (int i = 0; i < NI; i++) begin
        per = SC[i] + 1;
        if (t < len[i]) begin
          expect_eq($sformatf("%s_busy%0d_t%0d", tag, i, t), busy_w[i], 1);
          expect_eq($sformatf("%s_done%0d_t%0d", tag, i, t), done_w[i], 0);
          expect_eq($sformatf("%s_abc%0d_t%0d", tag, i, t), abc_w[i], (t / per) % 8);
        end else begin
          expect_eq($sformatf("%s_busy%0d_t%0d", tag, i, t), busy_w[i], 0);
          expect_eq($sformatf("%s_done%0d_t%0d", tag, i, t), done_w[i], 1);
          expect_eq($sformatf("%s_abc%0d_t%0d", tag, i, t), abc_w[i], 7);
        end
        if (t >= 1 && (t - 1) < len[i] && ((t - 1) % per) == SC[i]
            && vec_fails(i, 3'(((t - 1) / per) % 8))) begin
          expect_eq($sformatf("%s_ev%0d_t%0d", tag, i, t), ev_w[i], 1);
          expect_eq($sformatf("%s_evec%0d_t%0d", tag, i, t), evec_w[i], ((t - 1) / per) % 8);
        end else begin
          expect_eq($sformatf("%s_ev%0d_t%0d", tag, i, t), ev_w[i], 0);
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < NI; i++) begin
      npass = 0; nfail = 0; ffirst = -1;
      for (k = 0; k < 8 * RP[i]; k++) begin
        if (vec_fails(i, 3'(k % 8))) begin
          nfail++;
          if (ffirst < 0) ffirst = k % 8;
        end else begin
          npass++;
        end
      end
      expect_eq($sformatf("%s_pc%0d", tag, i), pc_w[i], (npass > 255) ? 255 : npass);
      expect_eq($sformatf("%s_fc%0d", tag, i), fc_w[i], (nfail > 255) ? 255 : nfail);
      expect_eq($sformatf("%s_af%0d", tag, i), af_w[i], (nfail > 0) ? 1 : 0);
      expect_eq($sformatf("%s_ffv%0d", tag, i), ffv_w[i], (ffirst < 0) ? 0 : ffirst);
    end
  endtask

  task automatic set_all(input logic [7:0] fm, input logic xe, input logic [2:0] xvv);
    for (int i = 0; i < NI; i++) begin
      flip[i] = fm;
      xen[i]  = xe;
      xv[i]   = xvv;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_all(8'h00, 1'b0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    check_idle_all("rst");
    reset = 1'b0;

    do_run("good", 1);
    set_all(8'hD8, 1'b0, 3'd0);   // stuck-at-0: vectors 3,4,6,7 fail
    do_run("stuck0", 1);
    set_all(8'hFF, 1'b0, 3'd0);   // inverted: every vector fails, REPEAT=40 saturates
    do_run("inv", 1);
    set_all(8'h00, 1'b1, 3'd5);
    do_run("xvec", 1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NI; i++) begin
        flip[i] = 8'($urandom_range(0, 255));
        xen[i]  = ($urandom_range(0, 3) == 0);
        xv[i]   = 3'($urandom_range(0, 7));
      end
      do_run($sformatf("rnd%0d", r), (r == 1) ? 6 : 1);
    end

    // Mid-sweep reset with start held high throughout the busy phase.
    set_all(8'hFF, 1'b0, 3'd0);
    @(posedge clk); #1;
    start = 1'b1;
    repeat (7) begin @(posedge clk); #1; end
    expect_eq("mid_abc0", abc_w[0], 3);
    expect_eq("mid_fc0", fc_w[0], 3);
    expect_eq("mid_busy0", busy_w[0], 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_all("midrst");
    reset = 1'b0;
    start = 1'b0;
    set_all(8'h00, 1'b0, 3'd0);
    do_run("post", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
